mem_arbiter: RTL

Shares a single unified single-port memory between the rv32 core's instruction-fetch (IF) port and load/store (LS) port. Arbitrates requests with fixed LS priority plus an IF anti-starvation guard, sequences exactly one outstanding memory transaction at a time, waits a parameterised memory latency, and returns registered read data / write acknowledges to the winning requester. It sits between the core (in place of separate imem/dmem instances) and the memory macro.

---
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the rv32 core's IF/LS ports, the arbiter and the
// unified single-port memory macro.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // instruction-fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // load/store port
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [BE_W-1:0]   ls_be;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    // memory macro port
    logic              mem_en;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // arbiter side
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // core + memory side
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between the core's fetch and
// load/store ports. One transaction in flight at a time; LS has priority
// except that IF wins a tie after two consecutive contested LS grants.
//
// state | meaning
// IDLE  | no transaction in flight; a request is granted combinationally
// WAIT  | waiting MEM_LAT cycles for the memory, then register the response
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output logic          busy
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        lat_cnt;
    logic              owner_ls;
    logic              owner_we;
    logic [1:0]        ls_streak;
    logic              grant_if;
    logic              grant_ls;
    logic              lat_done;
    logic              if_rvalid_q;
    logic              ls_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] ls_rdata_q;
    logic              mem_en_c;
    logic              mem_we_c;
    logic [BE_W-1:0]   mem_be_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    assign lat_done = (state == WAIT) && (lat_cnt == LAT_LAST);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_if || grant_ls) state_nxt = WAIT;
            WAIT:    if (lat_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // output logic: arbitration and memory strobes, only in IDLE and never
    // while reset is held so gnt/mem_en drop immediately on an async reset
    always_comb begin
        grant_if    = 1'b0;
        grant_ls    = 1'b0;
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_be_c    = '0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (state == IDLE && !rst) begin
            if (bus.ls_req && (!bus.if_req || ls_streak != 2'd2)) grant_ls = 1'b1;
            else if (bus.if_req)                                   grant_if = 1'b1;
        end
        if (grant_ls) begin
            mem_en_c    = 1'b1;
            mem_we_c    = bus.ls_we;
            mem_be_c    = bus.ls_we ? bus.ls_be : '1;
            mem_addr_c  = bus.ls_addr;
            mem_wdata_c = bus.ls_wdata;
        end else if (grant_if) begin
            mem_en_c    = 1'b1;
            mem_be_c    = '1;
            mem_addr_c  = bus.if_addr;
        end
    end

    // latency counter and owner capture at grant time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt  <= '0;
            owner_ls <= 1'b0;
            owner_we <= 1'b0;
        end else if (grant_if || grant_ls) begin
            lat_cnt  <= '0;
            owner_ls <= grant_ls;
            owner_we <= grant_ls & bus.ls_we;
        end else if (state == WAIT && !lat_done) begin
            lat_cnt  <= lat_cnt + 2'd1;
        end
    end

    // IF anti-starvation: count LS grants that beat a waiting fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                              ls_streak <= '0;
        else if (grant_if)                                    ls_streak <= '0;
        else if (grant_ls && bus.if_req && ls_streak != 2'd2) ls_streak <= ls_streak + 2'd1;
    end

    // response registers: one-cycle rvalid, rdata held until next response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if (lat_done) begin
                if (owner_ls) begin
                    ls_rvalid_q <= 1'b1;
                    ls_rdata_q  <= owner_we ? '0 : bus.mem_rdata;
                end else begin
                    if_rvalid_q <= 1'b1;
                    if_rdata_q  <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.if_gnt    = grant_if;
    assign bus.ls_gnt    = grant_ls;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.ls_rvalid = ls_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_be    = mem_be_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign busy          = (state == WAIT);
endmodule
